// File: rtl/mem_burst_pkg.sv
// Shared definitions for the on-chip burst responder.
//   state_e    : burst FSM states
//   GAP_CYCLES : idle cycles after each finish pulse before a new request is sampled
package mem_burst_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR      = 3'd1,
    ST_WR_LAST = 3'd2,
    ST_RD      = 3'd3,
    ST_RD_LAST = 3'd4,
    ST_FIN     = 3'd5,
    ST_GAP     = 3'd6
  } state_e;

  localparam int GAP_CYCLES = 1;

endpackage

// File: rtl/burst_ram.sv
// Single-port RAM backing the burst responder.
//   clk    : clock
//   rst_n  : sync active-low reset, clears only the read register (contents kept)
//   we     : write wdata to mem[addr]
//   re     : load mem[addr] into the read register (1-cycle latency)
//   addr   : word address
//   wdata  : write data
//   rdata  : registered read data, holds its value while re is low
module burst_ram #(
  parameter int DW = 16,
  parameter int AW = 12
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic          re,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [2**AW];
  logic [DW-1:0] rdata_q, rdata_d;

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  always_comb begin
    rdata_d = rdata_q;
    if (re) rdata_d = mem[addr];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) rdata_q <= '0;
    else        rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/mem_burst_responder.sv
// Memory-side responder for the rd_burst/wr_burst interface, serving one burst
// at a time from on-chip RAM instead of an SDRAM controller.
//   mem_clk, rst_n           : clock, sync active-low reset
//   rd_burst_req/len/addr    : read request, held until rd_burst_finish
//   rd_burst_data_valid/data : read data beats (data holds when valid is low)
//   rd_burst_finish          : 1-cycle pulse at end of read burst
//   wr_burst_req/len/addr    : write request, held until wr_burst_finish
//   wr_burst_data_req        : word request; initiator returns data one clock later
//   wr_burst_data            : write data
//   wr_burst_finish          : 1-cycle pulse at end of write burst
//   busy                     : FSM not idle
module mem_burst_responder
  import mem_burst_pkg::*;
#(
  parameter int MEM_DATA_BITS = 16,
  parameter int ADDR_BITS     = 24,
  parameter int BUSRT_BITS    = 10,
  parameter int RAM_ADDR_BITS = 12
) (
  input  logic                     mem_clk,
  input  logic                     rst_n,
  input  logic                     rd_burst_req,
  input  logic [BUSRT_BITS-1:0]    rd_burst_len,
  input  logic [ADDR_BITS-1:0]     rd_burst_addr,
  output logic                     rd_burst_data_valid,
  output logic [MEM_DATA_BITS-1:0] rd_burst_data,
  output logic                     rd_burst_finish,
  input  logic                     wr_burst_req,
  input  logic [BUSRT_BITS-1:0]    wr_burst_len,
  input  logic [ADDR_BITS-1:0]     wr_burst_addr,
  output logic                     wr_burst_data_req,
  input  logic [MEM_DATA_BITS-1:0] wr_burst_data,
  output logic                     wr_burst_finish,
  output logic                     busy
);

  state_e                  state_q, state_d;
  logic [ADDR_BITS-1:0]    addr_q, addr_d;
  logic [BUSRT_BITS-1:0]   len_q, len_d;
  logic [BUSRT_BITS-1:0]   cnt_q, cnt_d;   // requests/reads issued so far
  logic [BUSRT_BITS-1:0]   idx_q, idx_d;   // word offset of the next RAM access
  logic [3:0]              gap_q, gap_d;
  logic                    pref_wr_q, pref_wr_d;
  logic                    wr_req_q, wr_req_d;
  logic                    wr_cap_q, wr_cap_d; // data for last cycle's request is on the bus
  logic                    rd_vld_q, rd_vld_d;
  logic                    rd_fin_q, rd_fin_d;
  logic                    wr_fin_q, wr_fin_d;
  logic                    ram_re, grant_rd;
  logic [ADDR_BITS-1:0]    word_addr;
  logic                    unused_hi;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    gap_d     = gap_q;
    pref_wr_d = pref_wr_q;
    wr_req_d  = 1'b0;
    rd_fin_d  = 1'b0;
    wr_fin_d  = 1'b0;
    ram_re    = 1'b0;
    grant_rd  = 1'b0;

    if (wr_cap_q) idx_d = idx_q + BUSRT_BITS'(1);

    case (state_q)
      ST_IDLE: begin
        if (wr_burst_req || rd_burst_req) begin
          grant_rd = rd_burst_req && (!wr_burst_req || !pref_wr_q);
          // Preference only flips on a contested grant: the loser wins the next tie.
          if (wr_burst_req && rd_burst_req) pref_wr_d = grant_rd;
          addr_d = grant_rd ? rd_burst_addr : wr_burst_addr;
          len_d  = grant_rd ? rd_burst_len  : wr_burst_len;
          cnt_d  = BUSRT_BITS'(1);
          idx_d  = '0;
          if ((grant_rd ? rd_burst_len : wr_burst_len) == '0) begin
            state_d  = ST_FIN;
            rd_fin_d = grant_rd;
            wr_fin_d = !grant_rd;
          end else if (grant_rd) begin
            state_d = ST_RD;
          end else begin
            state_d  = ST_WR;
            wr_req_d = 1'b1;
          end
        end
      end
      ST_WR: begin
        if (cnt_q == len_q) begin
          state_d = ST_WR_LAST;
        end else begin
          wr_req_d = 1'b1;
          cnt_d    = cnt_q + BUSRT_BITS'(1);
        end
      end
      ST_WR_LAST: begin
        // Final word is captured on this edge.
        state_d  = ST_FIN;
        wr_fin_d = 1'b1;
      end
      ST_RD: begin
        ram_re = 1'b1;
        idx_d  = idx_q + BUSRT_BITS'(1);
        if (cnt_q == len_q) state_d = ST_RD_LAST;
        else                cnt_d   = cnt_q + BUSRT_BITS'(1);
      end
      ST_RD_LAST: begin
        // Final word leaves the RAM register this cycle.
        state_d  = ST_FIN;
        rd_fin_d = 1'b1;
      end
      ST_FIN: begin
        state_d = ST_GAP;
        gap_d   = '0;
      end
      ST_GAP: begin
        if (gap_q == 4'(GAP_CYCLES - 1)) state_d = ST_IDLE;
        else                             gap_d   = gap_q + 4'd1;
      end
      default: state_d = ST_IDLE;
    endcase

    wr_cap_d = wr_req_q;
    rd_vld_d = ram_re;
  end

  always_ff @(posedge mem_clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      len_q     <= '0;
      cnt_q     <= '0;
      idx_q     <= '0;
      gap_q     <= '0;
      pref_wr_q <= 1'b1;
      wr_req_q  <= 1'b0;
      wr_cap_q  <= 1'b0;
      rd_vld_q  <= 1'b0;
      rd_fin_q  <= 1'b0;
      wr_fin_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      gap_q     <= gap_d;
      pref_wr_q <= pref_wr_d;
      wr_req_q  <= wr_req_d;
      wr_cap_q  <= wr_cap_d;
      rd_vld_q  <= rd_vld_d;
      rd_fin_q  <= rd_fin_d;
      wr_fin_q  <= wr_fin_d;
    end
  end

  // Full-width sum; only the low RAM_ADDR_BITS index the RAM, so bursts wrap.
  assign word_addr = addr_q + ADDR_BITS'(idx_q);
  assign unused_hi = ^word_addr[ADDR_BITS-1:RAM_ADDR_BITS];

  // Gating with rst_n keeps an aborted burst from touching RAM on the reset edge.
  burst_ram #(
    .DW (MEM_DATA_BITS),
    .AW (RAM_ADDR_BITS)
  ) u_ram (
    .clk   (mem_clk),
    .rst_n (rst_n),
    .we    (wr_cap_q && rst_n),
    .re    (ram_re && rst_n),
    .addr  (word_addr[RAM_ADDR_BITS-1:0]),
    .wdata (wr_burst_data),
    .rdata (rd_burst_data)
  );

  assign rd_burst_data_valid = rd_vld_q;
  assign rd_burst_finish     = rd_fin_q;
  assign wr_burst_data_req   = wr_req_q;
  assign wr_burst_finish     = wr_fin_q;
  assign busy                = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mem_burst_responder.sv
// Scoreboard bench: drivers push expected beats/finishes (with their cycle) into
// queues; a negedge monitor pops and compares whenever the DUT shows activity.
module tb_mem_burst_responder;

  logic        mem_clk = 1'b0;
  logic        rst_n;
  logic        rd_burst_req, wr_burst_req;
  logic [9:0]  rd_burst_len, wr_burst_len;
  logic [23:0] rd_burst_addr, wr_burst_addr;
  logic [15:0] wr_burst_data;
  logic        rd_burst_data_valid, rd_burst_finish, wr_burst_data_req, wr_burst_finish, busy;
  logic [15:0] rd_burst_data;

  always #5 mem_clk = ~mem_clk;

  mem_burst_responder dut (
    .mem_clk(mem_clk), .rst_n(rst_n),
    .rd_burst_req(rd_burst_req), .rd_burst_len(rd_burst_len), .rd_burst_addr(rd_burst_addr),
    .rd_burst_data_valid(rd_burst_data_valid), .rd_burst_data(rd_burst_data),
    .rd_burst_finish(rd_burst_finish),
    .wr_burst_req(wr_burst_req), .wr_burst_len(wr_burst_len), .wr_burst_addr(wr_burst_addr),
    .wr_burst_data_req(wr_burst_data_req), .wr_burst_data(wr_burst_data),
    .wr_burst_finish(wr_burst_finish), .busy(busy)
  );

  typedef struct { int cyc; logic [15:0] data; } beat_t;
  typedef struct { int cyc; bit rd; } fin_t;

  int          cyc = 0;           // posedges seen; read at negedges
  int          total = 0, bad = 0;
  beat_t       exp_rd[$];
  int          exp_req[$];
  fin_t        exp_fin[$];
  logic [15:0] wq[$], fixed[$];
  logic [15:0] mem_m [4096];
  int          n_req_exp = 0, n_fin_exp = 0, n_req_seen = 0, n_fin_seen = 0;
  bit          pref_wr = 1'b1;
  int          last_f = -10;

  always @(posedge mem_clk) cyc <= cyc + 1;

  task automatic chk(string name, longint act, longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at cyc %0d", name, act, exp, cyc);
    end
  endtask

  // Reference model. A value "visible at cyc c" is what the initiator samples at
  // edge c+1. Accepted at edge k: write reqs visible k..k+len-1, read data k+1..k+len,
  // finish at k+len+1 (k when len is 0). Index = (addr+i) mod 4096.
  task automatic plan(bit rd, int addr, int len, int k, output int f);
    logic [15:0] d;
    int idx;
    f = (len == 0) ? k : k + len + 1;
    for (int i = 0; i < len; i++) begin
      idx = (addr + i) & 'hFFF;
      if (rd) exp_rd.push_back(beat_t'{k + 1 + i, mem_m[idx]});
      else begin
        d = (fixed.size() != 0) ? fixed.pop_front() : 16'($urandom);
        wq.push_back(d);
        exp_req.push_back(k + i);
        mem_m[idx] = d;
        n_req_exp++;
      end
    end
    exp_fin.push_back(fin_t'{f, rd});
    n_fin_exp++;
  endtask

  task automatic drive(bit rd, bit on, int addr, int len);
    if (rd) begin
      rd_burst_req = on;
      if (on) begin rd_burst_addr = addr[23:0]; rd_burst_len = len[9:0]; end
    end else begin
      wr_burst_req = on;
      if (on) begin wr_burst_addr = addr[23:0]; wr_burst_len = len[9:0]; end
    end
  endtask

  task automatic wait_idle();
    do @(negedge mem_clk); while (cyc < last_f + 2);
  endtask

  task automatic single(bit rd, int addr, int len, output int k);
    int f;
    wait_idle();
    drive(rd, 1'b1, addr, len);
    k = cyc + 1;
    plan(rd, addr, len, k, f);
    last_f = f;
    while (cyc < f) @(negedge mem_clk);
    drive(rd, 1'b0, 0, 0);
  endtask

  task automatic pair(int wa, int wl, int ra, int rl);
    int k1, f1, f2;
    bit first_rd;
    wait_idle();
    drive(1'b0, 1'b1, wa, wl);
    drive(1'b1, 1'b1, ra, rl);
    k1 = cyc + 1;
    first_rd = !pref_wr;
    if (first_rd) plan(1'b1, ra, rl, k1, f1);
    else          plan(1'b0, wa, wl, k1, f1);
    // loser stays requesting: accepted right after finish + GAP + IDLE
    plan(!first_rd, first_rd ? wa : ra, first_rd ? wl : rl, f1 + 3, f2);
    pref_wr = first_rd;
    while (cyc < f1) @(negedge mem_clk);
    drive(first_rd, 1'b0, 0, 0);
    while (cyc < f2) @(negedge mem_clk);
    drive(!first_rd, 1'b0, 0, 0);
    last_f = f2;
  endtask

  task automatic chk_outputs_zero(string tag);
    chk({tag, "_rd_valid"}, rd_burst_data_valid, 0);
    chk({tag, "_rd_data"},  rd_burst_data, 0);
    chk({tag, "_rd_fin"},   rd_burst_finish, 0);
    chk({tag, "_wr_req"},   wr_burst_data_req, 0);
    chk({tag, "_wr_fin"},   wr_burst_finish, 0);
    chk({tag, "_busy"},     busy, 0);
  endtask

  // Initiator write-data side: one word per data_req, presented a clock later.
  initial begin : data_drv
    bit req_seen;
    req_seen = 1'b0;
    forever begin
      @(negedge mem_clk);
      if (req_seen) wr_burst_data = (wq.size() != 0) ? wq.pop_front() : 16'hDEAD;
      req_seen = wr_burst_data_req;
    end
  end

  initial begin : monitor
    beat_t b;
    fin_t  f;
    forever begin
      @(negedge mem_clk);
      if (wr_burst_data_req === 1'b1) begin
        n_req_seen++;
        chk("wr_req_cyc", cyc, (exp_req.size() != 0) ? exp_req.pop_front() : -1);
      end
      if (rd_burst_data_valid === 1'b1) begin
        b = (exp_rd.size() != 0) ? exp_rd.pop_front() : beat_t'{-1, 16'h0};
        chk("rd_cyc", cyc, b.cyc);
        chk("rd_data", rd_burst_data, b.data);
      end
      if (wr_burst_finish === 1'b1 || rd_burst_finish === 1'b1) begin
        n_fin_seen++;
        f = (exp_fin.size() != 0) ? exp_fin.pop_front() : fin_t'{-1, 1'b0};
        chk("fin_cyc", cyc, f.cyc);
        chk("fin_is_rd", rd_burst_finish, f.rd);
        chk("fin_is_wr", wr_burst_finish, !f.rd);
      end
    end
  end

  initial begin : stim
    int k, pa, pl, wa, wl, ra, rl, off;
    rst_n = 1'b0;
    rd_burst_req = 1'b0; wr_burst_req = 1'b0;
    rd_burst_len = '0; wr_burst_len = '0;
    rd_burst_addr = '0; wr_burst_addr = '0;
    wr_burst_data = '0;
    repeat (3) @(negedge mem_clk);
    chk_outputs_zero("reset");
    rst_n = 1'b1;
    last_f = cyc - 2;

    // simultaneous requests: write first after reset, then read first
    pair('h200, 3, 'h200, 3);
    pair('h300, 2, 'h200, 3);

    // write then read back a len-4 burst
    fixed = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
    single(1'b0, 'h10, 4, k);
    single(1'b1, 'h10, 4, k);

    // zero-length write: finish only, busy for two cycles
    single(1'b0, 'h50, 0, k);
    chk("len0_busy0", busy, 1);
    @(negedge mem_clk);
    chk("len0_busy1", busy, 1);
    @(negedge mem_clk);
    chk("len0_busy2", busy, 0);

    // address wrap at RAM depth
    fixed = '{16'h00A0, 16'h00A1, 16'h00A2, 16'h00A3};
    single(1'b0, 'hFFE, 4, k);
    single(1'b1, 'h000, 2, k);
    single(1'b1, 'h123FFE, 4, k);

    // back-to-back len-128 writes with the request held throughout
    begin
      int k1, f1, f2;
      wait_idle();
      drive(1'b0, 1'b1, 'h900, 128);
      k1 = cyc + 1;
      plan(1'b0, 'h900, 128, k1, f1);
      while (cyc < f1) @(negedge mem_clk);
      drive(1'b0, 1'b1, 'h980, 128);
      plan(1'b0, 'h980, 128, f1 + 3, f2);
      while (cyc < f2) @(negedge mem_clk);
      drive(1'b0, 1'b0, 0, 0);
      last_f = f2;
    end
    single(1'b1, 'h9FE, 4, k);

    // randomized traffic, reads always inside the previously written region
    pa = 'h200; pl = 3;
    for (int it = 0; it < 14; it++) begin
      wa = (int'($urandom_range(0, 255)) << 16) | ('h100 + int'($urandom_range(0, 'h5FF)));
      wl = $urandom_range(0, 20);
      off = $urandom_range(0, pl);
      rl = $urandom_range(0, pl - off);
      ra = pa + off;
      if ($urandom_range(0, 1) == 0) begin
        single(1'b0, wa, wl, k);
        single(1'b1, ra, rl, k);
      end else begin
        pair(wa, wl, ra, rl);
      end
      pa = wa; pl = wl;
    end

    // reset while the 3rd data_req of a len-8 write is visible
    wait_idle();
    drive(1'b0, 1'b1, 'h800, 8);
    k = cyc + 1;
    for (int i = 0; i < 8; i++) wq.push_back(16'($urandom));
    for (int i = 0; i < 3; i++) exp_req.push_back(k + i);
    n_req_exp += 3;
    while (cyc < k + 2) @(negedge mem_clk);
    rst_n = 1'b0;
    @(negedge mem_clk);
    chk_outputs_zero("abort");
    drive(1'b0, 1'b0, 0, 0);
    rst_n = 1'b1;
    wq.delete();
    pref_wr = 1'b1;
    last_f = cyc - 2;
    single(1'b1, 'h10, 2, k);

    repeat (6) @(negedge mem_clk);
    chk("left_rd",  exp_rd.size(), 0);
    chk("left_req", exp_req.size(), 0);
    chk("left_fin", exp_fin.size(), 0);
    chk("req_total", n_req_seen, n_req_exp);
    chk("fin_total", n_fin_seen, n_fin_exp);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
